instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, number of clk cycles to wait after a step before sampling ROM outputs (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  permits issuing a new rom_step while high.
REQ-005 rom_instruction  input  9  instruction word driven by the program ROM.
REQ-006 rom_data  input  16  data word driven by the program ROM.
REQ-007 rom_step  output  1  registered one-cycle pulse; its rising edge advances the ROM address.
REQ-008 instr  output  9  captured instruction presented to the core.
REQ-009 data  output  16  captured data word presented to the core.
REQ-010 valid  output  1  instr/data hold a word not yet accepted.
REQ-011 ready  input  1  core accepts the word on an edge where valid && ready.
REQ-012 halted  output  1  HALT opcode fetched; fetching stopped.
REQ-013 fetch_count  output  8  words accepted so far (present only with FETCH_COUNT_EN).

Function
REQ-014 The FSM SHALL use exactly the states SETTLE, CAPTURE, PRESENT, STEP and HALT.
- SETTLE: count SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE: load rom_instruction/rom_data into instr/data.
- If the loaded word equals HALT_OPCODE (9'h100), go to HALT; otherwise go to PRESENT.
REQ-015 PRESENT SHALL hold valid=1 with instr/data stable until the edge where ready=1.
- On that edge, go to STEP if enable=1; otherwise go to an idle hold with valid=0.
- From the idle hold, go to STEP on the first edge where enable=1.
REQ-016 rom_step SHALL be high for exactly one cycle, the cycle after entering STEP; the FSM SHALL then go to SETTLE.
REQ-017 Latency: valid SHALL rise SETTLE_CYCLES+2 edges after the accepting edge (4 with default); the first valid after reset SHALL rise SETTLE_CYCLES+1 edges after rst deasserts.
REQ-018 The HALT word SHALL NOT be presented: valid=0, halted=1, and rom_step stays 0 until reset.
REQ-019 ready while valid=0 SHALL be ignored; enable low SHALL never truncate a rom_step pulse already issued.
REQ-020 ROM address wrap (255->0) is transparent; the block SHALL keep fetching.

Reset
REQ-021 While rst=1:
- state = SETTLE with settle counter cleared;
- rom_step, valid and halted = 0;
- instr = 9'h000 and data = 16'h0000;
- fetch_count = 0.
REQ-022 Reset mid-operation SHALL discard any presented word and SHALL NOT rewind the ROM; the next capture re-reads the ROM's current word.

Configuration
REQ-023 With FETCH_COUNT_EN defined, fetch_count SHALL increment by one on each accepting edge and wrap 255->0.
REQ-024 Without FETCH_COUNT_EN, the fetch_count port and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package cpu_pkg SHALL hold INSTR_W=9, DATA_W=16, HALT_OPCODE=9'h100 and the FSM state enumeration.
REQ-026 Sub-module step_pulser (one-cycle registered pulse on request) is the natural split; everything else stays in instr_fetch.

Verification
REQ-027 Reset release, ROM model word0 = 9'h012/16'h1234, ready=1 -> valid at edge 3, instr=9'h012, data=16'h1234, then rom_step pulses one cycle.
REQ-028 ready held 0 for 10 cycles -> valid stays 1, instr/data unchanged, rom_step stays 0; ready=1 -> accept, then rom_step pulses once.
REQ-029 ROM word 3 = 9'h100 -> after three accepted words, halted=1, valid=0, rom_step never pulses again, fetch_count=3.
REQ-030 enable=0 during PRESENT, then accept -> no rom_step until enable returns to 1; rom_step pulses on the cycle after enable rises.
REQ-031 rst asserted during SETTLE after word 5 -> all outputs 0 immediately; after release, the captured word equals ROM word 6.
REQ-032 260 continuous accepts -> fetch_count wraps to 4; no gaps beyond the REQ-017 latency.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, the HALT opcode and the fetch FSM state encoding for the
// instruction-fetch path.
package cpu_pkg;

  localparam int INSTR_W = 9;
  localparam int DATA_W  = 16;
  localparam logic [INSTR_W-1:0] HALT_OPCODE = 9'h100;

  typedef enum logic [2:0] {
    SETTLE  = 3'd0,
    CAPTURE = 3'd1,
    PRESENT = 3'd2,
    STEP    = 3'd3,
    HALT    = 3'd4
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return (word == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/step_pulser.sv
// Registers a one-cycle step request into the rom_step pulse so the ROM sees a
// glitch-free edge; the pulse is independent of enable once requested.
module step_pulser (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic pulse
);

  // pulse follows the request one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse <= 1'b0;
    end else begin
      pulse <= req;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Steps the program ROM, waits for its outputs to settle, captures instr/data
// and hands them to the core with a valid/ready handshake. Define
// FETCH_COUNT_EN to add the fetch_count port counting accepted words.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [INSTR_W-1:0] rom_instruction,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               rom_step,
  output logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  data,
  output logic               valid,
  input  logic               ready,
  output logic               halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [7:0]         fetch_count
`endif
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  fetch_state_t state_r;
  logic [3:0]   settle_cnt_r;
  logic         step_req_s;
  logic         accept_s;

  assign step_req_s = (state_r == STEP);
  assign accept_s   = (state_r == PRESENT) && valid && ready;

  step_pulser u_step_pulser (
    .clk   (clk),
    .rst   (rst),
    .req   (step_req_s),
    .pulse (rom_step)
  );

  // Fetch FSM; PRESENT with valid low doubles as the idle hold awaiting enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= SETTLE;
      settle_cnt_r <= 4'd0;
      instr        <= 9'h000;
      data         <= 16'h0000;
      valid        <= 1'b0;
      halted       <= 1'b0;
    end else begin
      case (state_r)
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            settle_cnt_r <= 4'd0;
            state_r      <= CAPTURE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        CAPTURE: begin
          if (is_halt(rom_instruction)) begin
            halted  <= 1'b1;
            state_r <= HALT;
          end else begin
            instr   <= rom_instruction;
            data    <= rom_data;
            valid   <= 1'b1;
            state_r <= PRESENT;
          end
        end
        PRESENT: begin
          if (valid) begin
            if (ready) begin
              valid <= 1'b0;
              if (enable) begin
                state_r <= STEP;
              end else begin
                state_r <= PRESENT;
              end
            end else begin
              state_r <= PRESENT;
            end
          end else if (enable) begin
            state_r <= STEP;
          end else begin
            state_r <= PRESENT;
          end
        end
        STEP: begin
          settle_cnt_r <= 4'd0;
          state_r      <= SETTLE;
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          valid        <= 1'b0;
          settle_cnt_r <= 4'd0;
          state_r      <= SETTLE;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  // Accepted-word counter, wraps naturally at 8 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 8'd0;
    end else if (accept_s) begin
      fetch_count <= fetch_count + 8'd1;
    end else begin
      fetch_count <= fetch_count;
    end
  end
`else
  logic unused_accept_s;
  assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural ROM that advances on each
// rising edge of rom_step; fetch_count checks apply when FETCH_COUNT_EN is set.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        ready = 1'b0;
  logic [8:0]  rom_instruction;
  logic [15:0] rom_data;
  logic        rom_step;
  logic [8:0]  instr;
  logic [15:0] data;
  logic        valid;
  logic        halted;
`ifdef FETCH_COUNT_EN
  logic [7:0]  fetch_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [8:0]  rom_i [256];
  logic [15:0] rom_d [256];
  logic [7:0]  step_cnt = 8'd0;
  logic [7:0]  base = 8'd0;
  logic [7:0]  rom_addr;

  instr_fetch #(.SETTLE_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .rom_instruction (rom_instruction),
    .rom_data        (rom_data),
    .rom_step        (rom_step),
    .instr           (instr),
    .data            (data),
    .valid           (valid),
    .ready           (ready),
    .halted          (halted)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count     (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge rom_step) step_cnt <= step_cnt + 8'd1;

  assign rom_addr        = step_cnt - base;
  assign rom_instruction = rom_i[rom_addr];
  assign rom_data        = rom_d[rom_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ready = 1'b0; enable = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (rom_step !== 1'b0) begin failures++; $display("FAIL reset_rom_step got=%b exp=0", rom_step); end
    checks++; if (instr !== 9'h000) begin failures++; $display("FAIL reset_instr got=%h exp=000", instr); end
    checks++; if (data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data); end
`ifdef FETCH_COUNT_EN
    checks++; if (fetch_count !== 8'd0) begin failures++; $display("FAIL reset_fetch_count got=%0d exp=0", fetch_count); end
`endif
  endtask

  task automatic test_first_fetch;
    logic early;
    base = step_cnt;
    ready = 1'b1;
    rst = 1'b0;
    tick(); early = valid;
    tick(); early = early | valid;
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL first_valid_early got=%b exp=0", early); end
    tick();
    checks++; if (valid !== 1'b1 || instr !== 9'h012 || data !== 16'h1234) begin
      failures++; $display("FAIL first_word got=%b/%h/%h exp=1/012/1234", valid, instr, data);
    end
    tick();
    checks++; if (valid !== 1'b0 || rom_step !== 1'b0) begin
      failures++; $display("FAIL accept_edge got=valid %b step %b exp=0/0", valid, rom_step);
    end
    ready = 1'b0;
    tick();
    checks++; if (rom_step !== 1'b1) begin failures++; $display("FAIL step_pulse_high got=%b exp=1", rom_step); end
    tick();
    checks++; if (rom_step !== 1'b0) begin failures++; $display("FAIL step_pulse_low got=%b exp=0", rom_step); end
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || instr !== rom_i[1] || data !== rom_d[1]) begin
      failures++; $display("FAIL latency_after_accept got=%b/%h/%h exp=1/%h/%h", valid, instr, data, rom_i[1], rom_d[1]);
    end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    int pulses = 0;
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid !== 1'b1 || instr !== rom_i[1] || data !== rom_d[1] || rom_step !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL hold_accept got=%b exp=0", valid); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rom_step === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL hold_step_pulses got=%0d exp=1", pulses); end
    checks++; if (valid !== 1'b1 || instr !== rom_i[2]) begin
      failures++; $display("FAIL hold_next_word got=%b/%h exp=1/%h", valid, instr, rom_i[2]);
    end
  endtask

  task automatic test_enable_gate;
    int bad = 0;
    logic [2:0] seq;
    enable = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL gate_accept got=%b exp=0", valid); end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rom_step !== 1'b0 || valid !== 1'b0) bad++;
    end
    ready = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL gate_idle got=%0d bad cycles exp=0", bad); end
    enable = 1'b1;
    tick(); seq[2] = rom_step;
    tick(); seq[1] = rom_step;
    tick(); seq[0] = rom_step;
    checks++; if (seq !== 3'b010) begin failures++; $display("FAIL gate_step_seq got=%b exp=010", seq); end
    tick(); tick();
    checks++; if (valid !== 1'b1 || instr !== rom_i[3]) begin
      failures++; $display("FAIL gate_next_word got=%b/%h exp=1/%h", valid, instr, rom_i[3]);
    end
  endtask

  task automatic test_halt;
    int nvalid = 0;
    int late_pulses = 0;
    rom_i[3] = 9'h100;
    rst = 1'b1;
    tick();
    base = step_cnt;
    rst = 1'b0; ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid === 1'b1) nvalid++;
      if (i >= 20 && rom_step === 1'b1) late_pulses++;
    end
    checks++; if (nvalid != 3) begin failures++; $display("FAIL halt_words got=%0d exp=3", nvalid); end
    checks++; if (halted !== 1'b1 || valid !== 1'b0) begin
      failures++; $display("FAIL halt_state got=halted %b valid %b exp=1/0", halted, valid);
    end
    checks++; if (late_pulses != 0) begin failures++; $display("FAIL halt_no_step got=%0d exp=0", late_pulses); end
`ifdef FETCH_COUNT_EN
    checks++; if (fetch_count !== 8'd3) begin failures++; $display("FAIL halt_fetch_count got=%0d exp=3", fetch_count); end
`endif
    ready = 1'b0;
    rom_i[3] = 9'h003;
  endtask

  task automatic test_reset_mid;
    int nvalid = 0;
    int n = 0;
    rst = 1'b1;
    tick();
    base = step_cnt;
    rst = 1'b0; ready = 1'b1;
    while (nvalid < 6 && n < 100) begin
      tick(); n++;
      if (valid === 1'b1) nvalid++;
    end
    checks++; if (nvalid != 6 || instr !== rom_i[5]) begin
      failures++; $display("FAIL mid_word5 got=%0d words instr %h exp=6/%h", nvalid, instr, rom_i[5]);
    end
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || halted !== 1'b0 || rom_step !== 1'b0 || instr !== 9'h000 || data !== 16'h0000) begin
      failures++; $display("FAIL mid_reset_outputs got=%b%b%b/%h/%h exp=000/000/0000", valid, halted, rom_step, instr, data);
    end
    checks++; if (rom_addr !== 8'd6) begin failures++; $display("FAIL mid_rom_addr got=%0d exp=6", rom_addr); end
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (valid !== 1'b1 || instr !== rom_i[6] || data !== rom_d[6]) begin
      failures++; $display("FAIL mid_recapture got=%b/%h/%h exp=1/%h/%h", valid, instr, data, rom_i[6], rom_d[6]);
    end
  endtask

  task automatic test_wrap;
    int nvalid = 0;
    int t = 0;
    int last = 0;
    int gaps = 0;
    int first_t = 0;
    rst = 1'b1;
    tick();
    base = step_cnt;
    rst = 1'b0; ready = 1'b1; enable = 1'b1;
    while (nvalid < 260 && t < 2000) begin
      tick(); t++;
      if (valid === 1'b1) begin
        if (nvalid == 0) first_t = t;
        else if (t - last != 5) gaps++;
        last = t;
        nvalid++;
      end
    end
    checks++; if (nvalid != 260) begin failures++; $display("FAIL wrap_words got=%0d exp=260", nvalid); end
    checks++; if (first_t != 3) begin failures++; $display("FAIL wrap_first_latency got=%0d exp=3", first_t); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL wrap_gaps got=%0d exp=0", gaps); end
    checks++; if (instr !== rom_i[3]) begin failures++; $display("FAIL wrap_word got=%h exp=%h", instr, rom_i[3]); end
    tick();
`ifdef FETCH_COUNT_EN
    checks++; if (fetch_count !== 8'd4) begin failures++; $display("FAIL wrap_fetch_count got=%0d exp=4", fetch_count); end
`endif
    ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom_i[i] = {1'b0, 8'(i)};
      rom_d[i] = {8'(i), ~8'(i)};
    end
    rom_i[0] = 9'h012;
    rom_d[0] = 16'h1234;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_enable_gate();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
